// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and widths for the triangle-sweep sequencer.
//   state_t : sequencer states (S_HOLD only reachable with SWEEP_DWELL_EN)
//   CW      : counter width
//   DW      : dwell counter width
package sweep_pkg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_HOLD
  } state_t;

endpackage

// File: rtl/count_udl.sv
// count_udl: 8-bit up/down counter with synchronous load.
// Ports:
//   ck   in  : clock (rising edge)
//   rst  in  : synchronous active-high reset, clears q
//   en   in  : count/load enable; q holds when low
//   ud   in  : direction, 1 = up, 0 = down
//   load in  : when enabled, q takes d (priority over counting)
//   d    in  : load value
//   q    out : counter value
module count_udl
  import sweep_pkg::*;
(
  input  logic          ck,
  input  logic          rst,
  input  logic          en,
  input  logic          ud,
  input  logic          load,
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      if (load)    r_q <= d;
      else if (ud) r_q <= CW'(r_q + 1'b1);
      else         r_q <= CW'(r_q - 1'b1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives a count_udl through lo -> hi -> lo triangle sweeps,
// for nper periods (nper = 0: until stop).
// Optional feature macro: SWEEP_DWELL_EN (adds dwell input and HOLD state
// that pauses at each turnaround).
// Ports:
//   ck, reset_n    : clock, synchronous active-low reset
//   start, stop    : start request (IDLE only), abort (wins over start)
//   lo, hi, nper   : sweep limits and period count, latched at start
//   dwell          : (SWEEP_DWELL_EN) extra cycles held at each turnaround
//   cnt            : counter value
//   busy           : high outside IDLE
//   done           : pulse on the final lo cycle of the last period
//   err            : pulse the cycle after a start with lo >= hi
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned PW = 4
) (
  input  logic          ck,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] lo,
  input  logic [CW-1:0] hi,
  input  logic [PW-1:0] nper,
`ifdef SWEEP_DWELL_EN
  input  logic [DW-1:0] dwell,
`endif
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        r_state;
  logic [CW-1:0] r_lo;
  logic [CW-1:0] r_hi;
  logic [PW-1:0] r_nper;
  logic [PW-1:0] r_per;
  logic          r_err;
`ifdef SWEEP_DWELL_EN
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] r_dw;
  logic          r_dir;
`endif

  logic [CW-1:0] w_cnt;
  logic          w_cnt_rst;
  logic          w_en;
  logic          w_ud;
  logic          w_load;
  logic          w_done;
  logic          w_at_hi;
  logic          w_at_lo;
  logic          w_last;
  logic          w_dwell_go;
  logic [PW-1:0] w_per_next;

  assign w_cnt_rst  = ~reset_n;
  assign w_at_hi    = (w_cnt == r_hi);
  assign w_at_lo    = (w_cnt == r_lo);
  assign w_per_next = PW'(r_per + 1'b1);
  // nper = 0 means free-running: the period counter is never compared
  assign w_last     = (r_nper != '0) && (w_per_next == r_nper);

`ifdef SWEEP_DWELL_EN
  assign w_dwell_go = (r_dwell != '0);
`else
  assign w_dwell_go = 1'b0;
`endif

  // Counter controls, decoded from state, current count and latched limits
  always_comb begin
    w_en   = 1'b0;
    w_ud   = 1'b0;
    w_load = 1'b0;
    w_done = 1'b0;
    if (!stop) begin
      case (r_state)
        S_LOAD: begin
          w_en   = 1'b1;
          w_load = 1'b1;
        end
        S_UP: begin
          if (!w_at_hi) begin
            w_en = 1'b1;
            w_ud = 1'b1;
          end else if (!w_dwell_go) begin
            w_en = 1'b1;
          end
        end
        S_DOWN: begin
          if (!w_at_lo) begin
            w_en = 1'b1;
          end else if (w_last) begin
            w_done = 1'b1;
          end else if (!w_dwell_go) begin
            w_en = 1'b1;
            w_ud = 1'b1;
          end
        end
`ifdef SWEEP_DWELL_EN
        S_HOLD: begin
          if (r_dw == '0) begin
            w_en = 1'b1;
            w_ud = r_dir;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer state, latched configuration and period counter
  always_ff @(posedge ck) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_nper  <= '0;
      r_per   <= '0;
      r_err   <= 1'b0;
`ifdef SWEEP_DWELL_EN
      r_dwell <= '0;
      r_dw    <= '0;
      r_dir   <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (lo < hi) begin
                r_lo    <= lo;
                r_hi    <= hi;
                r_nper  <= nper;
                r_per   <= '0;
`ifdef SWEEP_DWELL_EN
                r_dwell <= dwell;
`endif
                r_state <= S_LOAD;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_LOAD: r_state <= S_UP;
          S_UP: begin
            if (w_at_hi) begin
`ifdef SWEEP_DWELL_EN
              if (w_dwell_go) begin
                r_state <= S_HOLD;
                r_dw    <= DW'(r_dwell - 1'b1);
                r_dir   <= 1'b0;
              end else
`endif
              r_state <= S_DOWN;
            end
          end
          S_DOWN: begin
            if (w_at_lo) begin
              r_per <= w_per_next;
              if (w_last) begin
                r_state <= S_IDLE;
              end else begin
`ifdef SWEEP_DWELL_EN
                if (w_dwell_go) begin
                  r_state <= S_HOLD;
                  r_dw    <= DW'(r_dwell - 1'b1);
                  r_dir   <= 1'b1;
                end else
`endif
                r_state <= S_UP;
              end
            end
          end
`ifdef SWEEP_DWELL_EN
          S_HOLD: begin
            if (r_dw == '0) r_state <= r_dir ? S_UP : S_DOWN;
            else            r_dw    <= DW'(r_dw - 1'b1);
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  count_udl u_count (
    .ck   (ck),
    .rst  (w_cnt_rst),
    .en   (w_en),
    .ud   (w_ud),
    .load (w_load),
    .d    (r_lo),
    .q    (w_cnt)
  );

  assign cnt  = w_cnt;
  assign busy = (r_state != S_IDLE);
  assign done = w_done;
  assign err  = r_err;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed bench for sweep_ctrl (table of sweeps plus
// hand-written stop / reset / busy-start / dwell sequences).
module tb_sweep_ctrl;

  logic       ck;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] nper;
`ifdef SWEEP_DWELL_EN
  logic [3:0] dwell;
`endif
  logic [7:0] cnt;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;
  int exp_prev;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] nper;
    logic       exp_err;
    int         done_cyc;
  } vec_t;

  vec_t vecs[6];

  sweep_ctrl #(.PW(4)) dut (
    .ck      (ck),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .lo      (lo),
    .hi      (hi),
    .nper    (nper),
`ifdef SWEEP_DWELL_EN
    .dwell   (dwell),
`endif
    .cnt     (cnt),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected triangle value idx cycles after the first lo
  function automatic int ramp_val(input int l, input int h, input int idx);
    int span;
    int p;
    span = h - l;
    p = idx % (2 * span);
    if (p <= span) return l + p;
    return h - (p - span);
  endfunction

  task automatic run_sweep(input int vi);
    lo = vecs[vi].lo; hi = vecs[vi].hi; nper = vecs[vi].nper;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= vecs[vi].done_cyc; k++) begin
      if (k == 1) check($sformatf("v%0d_cnt_load", vi), cnt, exp_prev);
      else check($sformatf("v%0d_cnt_k%0d", vi, k), cnt,
                 ramp_val(vecs[vi].lo, vecs[vi].hi, k - 2));
      check($sformatf("v%0d_done_k%0d", vi, k), done, (k == vecs[vi].done_cyc) ? 1 : 0);
      check($sformatf("v%0d_busy_k%0d", vi, k), busy, 1);
      if (k < vecs[vi].done_cyc) tick();
    end
    tick();
    check($sformatf("v%0d_busy_end", vi), busy, 0);
    check($sformatf("v%0d_done_end", vi), done, 0);
    check($sformatf("v%0d_cnt_end", vi), cnt, vecs[vi].lo);
    exp_prev = vecs[vi].lo;
  endtask

  task automatic run_reject(input int vi);
    lo = vecs[vi].lo; hi = vecs[vi].hi; nper = vecs[vi].nper;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("v%0d_err", vi), err, 1);
    check($sformatf("v%0d_busy", vi), busy, 0);
    check($sformatf("v%0d_cnt", vi), cnt, exp_prev);
    tick();
    check($sformatf("v%0d_err_clr", vi), err, 0);
    check($sformatf("v%0d_busy_after", vi), busy, 0);
    check($sformatf("v%0d_cnt_after", vi), cnt, exp_prev);
  endtask

  initial begin
    checks = 0; errors = 0; exp_prev = 0;
    // lo, hi, nper, expect err, done cycle (1 + 2*N*(hi-lo) + 1)
    vecs[0] = '{8'd3,   8'd5,   4'd1, 1'b0, 6};
    vecs[1] = '{8'd7,   8'd7,   4'd1, 1'b1, 0};
    vecs[2] = '{8'd0,   8'd255, 4'd2, 1'b0, 1022};
    vecs[3] = '{8'd10,  8'd20,  4'd3, 1'b0, 62};
    vecs[4] = '{8'd9,   8'd3,   4'd2, 1'b1, 0};
    vecs[5] = '{8'd100, 8'd101, 4'd4, 1'b0, 10};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; nper = '0;
`ifdef SWEEP_DWELL_EN
    dwell = '0;
`endif
    tick(); tick();
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_err) run_reject(i);
      else run_sweep(i);
    end

`ifdef SWEEP_DWELL_EN
    begin
      int dseq[7];
      dseq = '{3, 4, 5, 5, 5, 4, 3};
      lo = 8'd3; hi = 8'd5; nper = 4'd1; dwell = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 2; k <= 8; k++) begin
        tick();
        check($sformatf("dwell_cnt_k%0d", k), cnt, dseq[k-2]);
        check($sformatf("dwell_done_k%0d", k), done, (k == 8) ? 1 : 0);
      end
      tick();
      check("dwell_busy_end", busy, 0);
      dwell = '0;
    end
`endif

    // Free-running sweep, ignored start while busy, stop in DOWN at 11
    lo = 8'd10; hi = 8'd12; nper = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("stop_cnt_k2", cnt, 10);
    tick();
    check("stop_cnt_k3", cnt, 11);
    lo = 8'd0; hi = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_cnt_k4", cnt, 12);
    check("busy_start_busy", busy, 1);
    tick();
    check("stop_cnt_k5", cnt, 11);
    tick();
    check("stop_cnt_k6", cnt, 10);
    check("stop_nodone_k6", done, 0);
    tick();
    check("stop_cnt_k7", cnt, 11);
    check("stop_busy_k7", busy, 1);
    tick();
    check("stop_cnt_k8", cnt, 12);
    tick();
    check("stop_cnt_k9", cnt, 11);
    stop = 1'b1;
    #1;
    check("stop_nodone", done, 0);
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_cnt_frozen", cnt, 11);
    check("stop_done_after", done, 0);
    tick();
    check("stop_cnt_hold", cnt, 11);

    // start and stop together in IDLE: stop wins
    lo = 8'd1; hi = 8'd4; nper = 4'd1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_err", err, 0);
    tick();
    check("ss_busy2", busy, 0);
    check("ss_cnt", cnt, 11);

    // Reset mid-sweep
    lo = 8'd50; hi = 8'd60; nper = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid_cnt_pre", cnt, 53);
    reset_n = 1'b0;
    tick();
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    tick();
    check("mid_rst_cnt2", cnt, 0);
    reset_n = 1'b1;
    tick();
    check("mid_rst_idle_busy", busy, 0);
    check("mid_rst_idle_cnt", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for the 8-bit bidirectional counter `count_udl`. It drives the counter's `en`/`ud`/`load`/`d` controls to produce a triangle sweep between two programmable limits, `lo → hi → lo`, for a programmable number of periods or continuously. It instantiates one `count_udl` and exposes its value. It sits between a host/config interface and any consumer of a ramp value, such as a PWM compare or a DAC code.

## Interface
Parameters:
- `PW`, default 4: width of the period-count input.

Ports:
- `ck` in 1: clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `stop` in 1: abort; highest priority after reset.
- `lo` in 8: lower limit; latched at accepted start.
- `hi` in 8: upper limit; latched at accepted start.
- `nper` in PW: number of full periods; 0 = run until stop; latched at accepted start.
- `cnt` out 8: counter value (`count_udl` output).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the final period completes.
- `err` out 1: one-cycle pulse when start is rejected.

## Operation
- States are IDLE, LOAD, UP, DOWN (plus HOLD, see Configuration).
- Reset:
  - State = IDLE; `busy`/`done`/`err` = 0.
  - Latched limits and period counter = 0.
  - The counter's reset is driven as `~reset_n`, so `cnt` = 0.
- IDLE:
  - Counter held (`en`=0).
  - On `start` with `lo < hi` → LOAD.
  - On `start` with `lo >= hi` → `err` pulse next cycle, remain IDLE.
- LOAD: `en`=1, `load`=1, `d`=`lo_q` → UP.
- UP:
  - `en`=1.
  - If `cnt != hi_q`: `ud`=1.
  - Else: `ud`=0 (turn around, no dwell) → DOWN.
- DOWN:
  - If `cnt != lo_q`: `en`=1, `ud`=0.
  - Else the period ends and the period counter increments.
  - If `nper != 0` and the count reaches `nper_q`: `en`=0, `done`=1, → IDLE.
  - Otherwise: `en`=1, `ud`=1, → UP.
- Controls are combinational from state, `cnt` and the latched limits. State and the period counter are registered.
- Value sequence: `lo, lo+1, …, hi, hi-1, …, lo`. Each value is held one cycle, and `lo` is shared between consecutive periods.
- `stop` in any non-IDLE state: `en`=0 that cycle, → IDLE, `cnt` frozen at its current value, no `done`.
- `start` while busy is ignored.
- `start` and `stop` together in IDLE: `stop` wins and the start is ignored.
- No wrap-around is possible, because `lo < hi` is enforced. `hi`=255 and `lo`=0 are legal.
- Period counter is PW bits. With `nper`=0 it wraps freely and is never compared.
- Reset mid-sweep: IDLE and `cnt`=0 on the next edge.

## Timing
- Start sampled at edge E0 → LOAD during cycle 1 → `cnt`=`lo` after edge E1.
- One period takes `2·(hi−lo)` cycles in UP/DOWN. The final `lo` cycle carries `done`.
- With `nper`=N, `done` is asserted in cycle `1 + 2·N·(hi−lo) + 1` after E0. `busy` falls on the following edge.
- `err` is asserted in the cycle after the rejecting start edge.
- Stop latency: state is IDLE one edge after `stop` is sampled. `cnt` does not change on that edge.

## Configuration
- `SWEEP_DWELL_EN` defined:
  - Adds input `dwell` (4 bits), latched at start, and state HOLD with a 4-bit dwell counter.
  - On reaching `hi` in UP, or `lo` in DOWN (not final), the FSM enters HOLD with `en`=0.
  - HOLD lasts `dwell` extra cycles, then resumes in the opposite direction.
  - `dwell`=0 is identical to the undefined build.
  - `stop` aborts HOLD.
  - No dwell occurs at the initial `lo` after LOAD.
- Undefined: no `dwell` port, no HOLD state, timing exactly as in Timing above.

## Structure
- `sweep_pkg`:
  - State typedef (IDLE, LOAD, UP, DOWN, HOLD).
  - Counter width constant `CW = 8`.
  - Dwell width constant `DW = 4`.
- Sub-module: one instance of `count_udl`. All sequencing lives in `sweep_ctrl`.

## Test plan
- Reset with `reset_n`=0 for 2 cycles mid-sweep → `cnt`=0, `busy`=0, `done`=0 on the next edge.
- `lo`=3, `hi`=5, `nper`=1, start → `cnt` = 3,4,5,4,3. `done` is high in the second `cnt`=3 cycle (cycle 6 after the start edge). `cnt` stays 3 afterwards.
- `lo`=0, `hi`=255, `nper`=2 → two full sweeps, 1020 UP/DOWN cycles, one `done` pulse.
- `lo`=7, `hi`=7, start → `err` pulse, `busy` stays 0, `cnt` unchanged.
- `nper`=0, `lo`=10, `hi`=12; `stop` asserted while `cnt`=11 in DOWN → IDLE next edge, `cnt` stays 11, no `done`. A `start` during busy earlier in the run is ignored.
- `SWEEP_DWELL_EN`, `dwell`=2, `lo`=3, `hi`=5, `nper`=1 → `cnt` = 3,4,5,5,5,4,3, with `done` on the final 3.
